// File: rtl/axi_hdmi_tx_pkg.sv
// Shared definitions for the HDMI TX VDMA-side frame sequencer:
// state encodings, status bit positions and default timing constants.
package axi_hdmi_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARM      = 3'd1,
        ST_WAIT_RET = 3'd2,
        ST_ACTIVE   = 3'd3,
        ST_RECOVER  = 3'd4
    } ctrl_state_e;

    localparam int STAT_OVF  = 0;
    localparam int STAT_UNF  = 1;
    localparam int STAT_MISS = 2;
    localparam int STAT_TMO  = 3;
    localparam int STAT_OOS  = 4;
    localparam int STAT_W    = 5;

    localparam logic [23:0] DEF_RET_TIMEOUT  = 24'd4000000;
    localparam logic [7:0]  DEF_FLUSH_CYCLES = 8'd16;

endpackage

// File: rtl/axi_hdmi_tx_vdma_ctrl_if.sv
// Frame handshake and buffer-health signals between the sequencer (master)
// and the buffer/VDMA side (slave).
interface axi_hdmi_tx_vdma_ctrl_if;

    logic vdma_fs;
    logic vdma_fs_ret;
    logic vdma_ovf;
    logic vdma_unf;
    logic vdma_tpm_oos;
    logic vdma_fs_req;
    logic buf_flush;

    modport master (
        input  vdma_fs,
        input  vdma_fs_ret,
        input  vdma_ovf,
        input  vdma_unf,
        input  vdma_tpm_oos,
        output vdma_fs_req,
        output buf_flush
    );

    modport slave (
        output vdma_fs,
        output vdma_fs_ret,
        output vdma_ovf,
        output vdma_unf,
        output vdma_tpm_oos,
        input  vdma_fs_req,
        input  buf_flush
    );

endinterface

// File: rtl/axi_hdmi_tx_sat_cnt.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an
// increment restarts the count at one so that cycle is not lost.
module axi_hdmi_tx_sat_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // NOTE: state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? WIDTH'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/axi_hdmi_tx_vdma_ctrl.sv
// Frame sequencer for the HDMI TX VDMA path: gates frame requests, watches the
// frame-return handshake with a timeout and runs a flush/resync on errors.
module axi_hdmi_tx_vdma_ctrl
    import axi_hdmi_tx_pkg::*;
#(
    parameter logic [23:0] RET_TIMEOUT  = DEF_RET_TIMEOUT,
    parameter logic [7:0]  FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter logic        RECOVER_EN   = 1'b1
) (
    input  logic                          vdma_clk,
    input  logic                          vdma_rstn,
    input  logic                          ctrl_enable,
    input  logic [STAT_W-1:0]             status_clr,
    axi_hdmi_tx_vdma_ctrl_if.master       bus,
    output logic                          ctrl_busy,
    output logic [2:0]                    ctrl_state,
    output logic [15:0]                   frame_count,
    output logic [7:0]                    ovf_count,
    output logic [7:0]                    unf_count,
    output logic [STAT_W-1:0]             status
);

    ctrl_state_e         state_q, state_d;
    logic [23:0]         tmo_q, tmo_d;
    logic [7:0]          flush_cnt_q, flush_cnt_d;
    logic [15:0]         frame_q, frame_d;
    logic [STAT_W-1:0]   status_q, status_d, status_set;
    logic                req_q, req_d;
    logic                flush_q;
    logic                busy_q;
    logic                miss_set, tmo_set;
    logic                ovf_inc, unf_inc;

    // NOTE: every always_comb output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        flush_cnt_d = flush_cnt_q;
        frame_d     = frame_q;
        req_d       = 1'b0;
        miss_set    = 1'b0;
        tmo_set     = 1'b0;

        if (!ctrl_enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARM;
                ST_ARM: begin
                    if (bus.vdma_fs) begin
                        req_d   = 1'b1;
                        tmo_d   = '0;
                        state_d = ST_WAIT_RET;
                    end
                end
                ST_WAIT_RET: begin
                    // A frame-sync before the return means the buffer moved on.
                    miss_set = bus.vdma_fs;
                    if (bus.vdma_fs_ret) begin
                        state_d = ST_ACTIVE;
                        frame_d = frame_q + 16'd1;
                    end else if (tmo_q == RET_TIMEOUT - 24'd1) begin
                        state_d     = ST_RECOVER;
                        tmo_set     = 1'b1;
                        flush_cnt_d = '0;
                    end else begin
                        tmo_d = tmo_q + 24'd1;
                    end
                end
                ST_ACTIVE: begin
                    if (RECOVER_EN && (bus.vdma_ovf || bus.vdma_unf)) begin
                        state_d     = ST_RECOVER;
                        flush_cnt_d = '0;
                    end else if (bus.vdma_fs) begin
                        req_d   = 1'b1;
                        tmo_d   = '0;
                        state_d = ST_WAIT_RET;
                    end
                end
                ST_RECOVER: begin
                    if (flush_cnt_q == FLUSH_CYCLES - 8'd1) begin
                        state_d = ST_ARM;
                    end else begin
                        flush_cnt_d = flush_cnt_q + 8'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign ovf_inc = bus.vdma_ovf && (state_q != ST_IDLE);
    assign unf_inc = bus.vdma_unf && (state_q != ST_IDLE);

    always_comb begin
        status_set            = '0;
        status_set[STAT_OVF]  = ovf_inc;
        status_set[STAT_UNF]  = unf_inc;
        status_set[STAT_MISS] = miss_set;
        status_set[STAT_TMO]  = tmo_set;
        status_set[STAT_OOS]  = bus.vdma_tpm_oos;
        // Set has priority over a same-cycle clear.
        status_d = (status_q & ~status_clr) | status_set;
    end

    always_ff @(posedge vdma_clk or negedge vdma_rstn) begin
        if (!vdma_rstn) begin
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            flush_cnt_q <= '0;
            frame_q     <= '0;
            status_q    <= '0;
            req_q       <= 1'b0;
            flush_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            flush_cnt_q <= flush_cnt_d;
            frame_q     <= frame_d;
            status_q    <= status_d;
            req_q       <= req_d;
            flush_q     <= (state_d == ST_RECOVER);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    axi_hdmi_tx_sat_cnt #(.WIDTH(8)) u_ovf_cnt (
        .clk   (vdma_clk),
        .rst_n (vdma_rstn),
        .inc   (ovf_inc),
        .clr   (status_clr[STAT_OVF]),
        .count (ovf_count)
    );

    axi_hdmi_tx_sat_cnt #(.WIDTH(8)) u_unf_cnt (
        .clk   (vdma_clk),
        .rst_n (vdma_rstn),
        .inc   (unf_inc),
        .clr   (status_clr[STAT_UNF]),
        .count (unf_count)
    );

    assign bus.vdma_fs_req = req_q;
    assign bus.buf_flush   = flush_q;
    assign ctrl_busy       = busy_q;
    assign ctrl_state      = state_q;
    assign frame_count     = frame_q;
    assign status          = status_q;

endmodule

// File: tb/tb_axi_hdmi_tx_vdma_ctrl.sv
// Directed bench for the VDMA frame sequencer; request timing is tracked by a
// scoreboard of expected request cycles.
module tb_axi_hdmi_tx_vdma_ctrl;

    logic        clk;
    logic        rstn;
    logic        ctrl_enable;
    logic [4:0]  status_clr;
    logic        ctrl_busy;
    logic [2:0]  ctrl_state;
    logic [15:0] frame_count;
    logic [7:0]  ovf_count;
    logic [7:0]  unf_count;
    logic [4:0]  status;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_q[$];
    logic prev_req = 1'b0;

    axi_hdmi_tx_vdma_ctrl_if vif ();

    axi_hdmi_tx_vdma_ctrl #(
        .RET_TIMEOUT  (24'd20),
        .FLUSH_CYCLES (8'd16),
        .RECOVER_EN   (1'b1)
    ) dut (
        .vdma_clk    (clk),
        .vdma_rstn   (rstn),
        .ctrl_enable (ctrl_enable),
        .status_clr  (status_clr),
        .bus         (vif),
        .ctrl_busy   (ctrl_busy),
        .ctrl_state  (ctrl_state),
        .frame_count (frame_count),
        .ovf_count   (ovf_count),
        .unf_count   (unf_count),
        .status      (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic fs_pulse(input bit expect_req);
        vif.vdma_fs = 1'b1;
        if (expect_req) exp_q.push_back(cyc + 1);
        tick();
        vif.vdma_fs = 1'b0;
    endtask

    task automatic ret_pulse();
        vif.vdma_fs_ret = 1'b1;
        tick();
        vif.vdma_fs_ret = 1'b0;
    endtask

    // Request monitor: every request must be scoreboarded and never back-to-back.
    always @(negedge clk) begin
        if (rstn && vif.vdma_fs_req) begin
            int e;
            check("req_gap", prev_req, 1'b0);
            check("req_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("req_cycle", cyc, e);
            end
        end
        prev_req <= vif.vdma_fs_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rstn             = 1'b0;
        ctrl_enable      = 1'b0;
        status_clr       = '0;
        vif.vdma_fs      = 1'b0;
        vif.vdma_fs_ret  = 1'b0;
        vif.vdma_ovf     = 1'b0;
        vif.vdma_unf     = 1'b0;
        vif.vdma_tpm_oos = 1'b0;

        tick(2);
        check("reset_outputs", {vif.vdma_fs_req, vif.buf_flush, ctrl_busy, ctrl_state,
                                frame_count, ovf_count, unf_count, status}, 64'd0);
        rstn = 1'b1;
        tick();
        check("idle_disabled", ctrl_state, 3'd0);

        // Normal frame
        ctrl_enable = 1'b1;
        tick();
        check("arm_state", {ctrl_busy, ctrl_state}, {1'b1, 3'd1});
        tick(3);
        fs_pulse(1);
        check("first_req", {vif.vdma_fs_req, ctrl_state}, {1'b1, 3'd2});
        tick(9);
        ret_pulse();
        check("active_frame1", {ctrl_state, frame_count}, {3'd3, 16'd1});
        tick(2);
        fs_pulse(1);
        check("active_to_wait", ctrl_state, 3'd2);
        tick(4);
        ret_pulse();
        check("active_frame2", {ctrl_state, frame_count}, {3'd3, 16'd2});

        // Return timeout after 20 cycles in WAIT_RET
        fs_pulse(1);
        tick(19);
        check("wait_before_tmo", ctrl_state, 3'd2);
        tick();
        check("tmo_recover", {ctrl_state, status, vif.buf_flush}, {3'd4, 5'b01000, 1'b1});
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!vif.buf_flush) break;
            n++;
            vif.vdma_fs     = (i == 5);
            vif.vdma_fs_ret = (i == 7);
            tick();
        end
        vif.vdma_fs     = 1'b0;
        vif.vdma_fs_ret = 1'b0;
        check("flush_len", n, 16);
        check("recover_to_arm", {ctrl_state, frame_count}, {3'd1, 16'd2});
        status_clr = 5'b01000;
        tick();
        status_clr = '0;
        check("clr_tmo", status, 5'b00000);

        // Missed frame
        fs_pulse(1);
        tick(3);
        fs_pulse(0);
        check("miss_flag", {status, ctrl_state, vif.vdma_fs_req}, {5'b00100, 3'd2, 1'b0});
        tick(2);
        ret_pulse();
        check("miss_then_ret", {ctrl_state, frame_count}, {3'd3, 16'd3});
        status_clr = 5'b00100;
        tick();
        status_clr = '0;
        check("clr_miss", status, 5'b00000);

        // Overflow colliding with frame-sync in ACTIVE
        vif.vdma_ovf = 1'b1;
        vif.vdma_fs  = 1'b1;
        tick();
        vif.vdma_ovf = 1'b0;
        vif.vdma_fs  = 1'b0;
        check("collision", {ctrl_state, vif.vdma_fs_req, ovf_count, status},
              {3'd4, 1'b0, 8'd1, 5'b00001});
        status_clr   = 5'b00001;
        vif.vdma_ovf = 1'b1;
        tick();
        vif.vdma_ovf = 1'b0;
        check("set_beats_clr", status, 5'b00001);
        tick();
        status_clr = '0;
        check("clr_ovf", {status, ovf_count}, {5'b00000, 8'd0});
        for (int i = 0; i < 40 && ctrl_state != 3'd1; i++) tick();
        check("recover_done", ctrl_state, 3'd1);

        // Underflow saturation, then disable during RECOVER
        vif.vdma_unf = 1'b1;
        tick(300);
        vif.vdma_unf = 1'b0;
        check("unf_saturate", {unf_count, status, ctrl_state}, {8'd255, 5'b00010, 3'd1});
        fs_pulse(1);
        tick(2);
        ret_pulse();
        check("frame4", frame_count, 16'd4);
        vif.vdma_unf = 1'b1;
        tick();
        vif.vdma_unf = 1'b0;
        check("unf_recover", {ctrl_state, unf_count}, {3'd4, 8'd255});
        tick(3);
        ctrl_enable = 1'b0;
        tick();
        check("disable_in_recover", {ctrl_state, vif.buf_flush, ctrl_busy, frame_count, unf_count, status},
              {3'd0, 1'b0, 1'b0, 16'd4, 8'd255, 5'b00010});
        status_clr = 5'b00010;
        tick();
        status_clr = '0;
        check("clr_unf", {unf_count, status}, {8'd0, 5'b00000});
        vif.vdma_unf = 1'b1;
        tick();
        vif.vdma_unf = 1'b0;
        check("idle_ignores_unf", {unf_count, status}, {8'd0, 5'b00000});
        vif.vdma_tpm_oos = 1'b1;
        tick();
        vif.vdma_tpm_oos = 1'b0;
        check("oos_flag", status, 5'b10000);
        status_clr = 5'b10000;
        tick();
        status_clr = '0;
        check("clr_oos", status, 5'b00000);

        // Asynchronous reset in the middle of WAIT_RET
        ctrl_enable = 1'b1;
        tick();
        fs_pulse(1);
        tick(5);
        check("pre_reset_wait", ctrl_state, 3'd2);
        rstn = 1'b0;
        #1;
        check("async_reset", {vif.vdma_fs_req, vif.buf_flush, ctrl_busy, ctrl_state,
                              frame_count, ovf_count, unf_count, status}, 64'd0);
        tick();
        rstn = 1'b1;
        #1;
        check("post_reset_idle", ctrl_state, 3'd0);
        tick();
        check("post_reset_arm", ctrl_state, 3'd1);
        fs_pulse(1);
        tick(19);
        check("fresh_tmo_wait", ctrl_state, 3'd2);
        tick();
        check("fresh_tmo_recover", ctrl_state, 3'd4);

        tick(2);
        check("req_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_hdmi_tx_vdma_ctrl.md
Name: axi_hdmi_tx_vdma_ctrl

Overview:
- Frame sequencer for the HDMI TX VDMA-side buffer path, in the vdma_clk domain.
- Gates frame-start requests from the buffer's frame-sync pulse to the VDMA core and supervises the frame-return handshake with a timeout.
- Monitors buffer overflow, underflow and test-pattern out-of-sync flags; on errors it runs a flush/resync recovery sequence.
- Exposes counters and sticky status to the register map.

Parameters:
- RET_TIMEOUT, 24'd4000000, cycles to wait in WAIT_RET for vdma_fs_ret before declaring a timeout.
- FLUSH_CYCLES, 8'd16, cycles buf_flush stays asserted in RECOVER.
- RECOVER_EN, 1'b1, when 1, ovf/unf seen in ACTIVE forces RECOVER; when 0, they are only counted.

Ports:
- vdma_clk  in  1  clock
- vdma_rstn  in  1  reset, asynchronous, active-low
- ctrl_enable  in  1  level; 0 forces IDLE
- vdma_fs  in  1  one-cycle frame-sync pulse from the buffer block
- vdma_fs_ret  in  1  one-cycle frame-return pulse from the VDMA core
- vdma_ovf  in  1  buffer overflow flag, registered level
- vdma_unf  in  1  buffer underflow flag, registered level
- vdma_tpm_oos  in  1  test-pattern out-of-sync flag
- status_clr  in  5  write-one-to-clear pulse mask for status
- vdma_fs_req  out  1  one-cycle frame request to the VDMA core
- buf_flush  out  1  buffer flush/resync level
- ctrl_busy  out  1  high in every state except IDLE
- ctrl_state  out  3  current state encoding
- frame_count  out  16  completed frames, wraps
- ovf_count  out  8  saturating count of cycles with vdma_ovf high
- unf_count  out  8  saturating count of cycles with vdma_unf high
- status  out  5  sticky bits {oos, timeout, miss, unf, ovf}

Behaviour:
- Reset (vdma_rstn=0, asynchronous):
  - state=IDLE.
  - All outputs 0: vdma_fs_req, buf_flush, ctrl_busy, ctrl_state, frame_count, ovf_count, unf_count, status.
  - Timeout and flush counters 0.
- All outputs are registered.
- States: IDLE=0, ARM=1, WAIT_RET=2, ACTIVE=3, RECOVER=4. Codes 5–7 go to IDLE.
- IDLE: stays while ctrl_enable=0; goes to ARM when ctrl_enable=1.
- ARM: on vdma_fs -> vdma_fs_req=1 the next cycle; state=WAIT_RET; timeout counter cleared.
- WAIT_RET:
  - Timeout counter increments every cycle.
  - On vdma_fs_ret -> ACTIVE; frame_count+1.
  - When the counter reaches RET_TIMEOUT-1 with no return -> RECOVER; status.timeout set.
  - If vdma_fs arrives before the return: status.miss set, no new request, stay in WAIT_RET.
  - vdma_fs_ret and timeout in the same cycle: return wins.
- ACTIVE:
  - On vdma_fs -> vdma_fs_req next cycle; state=WAIT_RET.
  - If RECOVER_EN=1 and (vdma_ovf|vdma_unf) -> RECOVER.
  - Error and vdma_fs in the same cycle: error wins, no request issued.
- RECOVER:
  - buf_flush=1 for exactly FLUSH_CYCLES cycles starting the cycle after entry.
  - Then buf_flush=0 and state=ARM; the next frame is resynced from a fresh vdma_fs.
  - vdma_fs and vdma_fs_ret are ignored during RECOVER.
- ctrl_enable=0 in any state -> IDLE on the next cycle.
  - buf_flush and vdma_fs_req drop with the transition.
  - An in-flight frame is abandoned; frame_count and status are held.
- vdma_fs_ret outside WAIT_RET: ignored.
- Latency: vdma_fs to vdma_fs_req is exactly 1 cycle. vdma_fs_req is never high on two consecutive cycles.
- Counters:
  - ovf_count/unf_count increment on each cycle the flag is high while state != IDLE; saturate at 255.
  - Cleared when the matching status_clr bit is written.
  - frame_count wraps 65535 -> 0.
- Sticky status:
  - ovf/unf bits are set on any flag cycle outside IDLE.
  - oos bit is set by vdma_tpm_oos.
  - Each bit is cleared by its status_clr bit; a set in the same cycle as a clear wins (bit stays 1).
- ctrl_state mirrors the registered state; ctrl_busy = (state != IDLE).

Decomposition:
- Shared package axi_hdmi_tx_pkg:
  - state enum constants (3-bit);
  - status bit indices STAT_OVF=0, STAT_UNF=1, STAT_MISS=2, STAT_TMO=3, STAT_OOS=4;
  - default RET_TIMEOUT and FLUSH_CYCLES.
- One sub-module, axi_hdmi_tx_sat_cnt: parameterized-width saturating counter with inc/clr, async active-low reset. Instantiated for ovf_count and unf_count.

Test Plan:
- Reset mid-WAIT_RET with timeout counter at 100 -> all outputs 0 immediately; state IDLE after release.
- Normal frame: enable, vdma_fs at cycle 10 -> vdma_fs_req at cycle 11; vdma_fs_ret at cycle 50 -> state ACTIVE, frame_count=1; next vdma_fs -> new request, WAIT_RET.
- Timeout: RET_TIMEOUT=20, no return -> RECOVER after 20 cycles in WAIT_RET; status[3]=1; buf_flush high 16 cycles; then ARM.
- Missed frame: second vdma_fs while in WAIT_RET -> status[2]=1, no second vdma_fs_req; a later return still gives frame_count=1.
- Collision: vdma_ovf and vdma_fs in the same ACTIVE cycle -> RECOVER, no request, ovf_count=1, status[0]=1; status_clr=5'b00001 together with a new ovf cycle -> status[0] stays 1.
- Saturation and disable: hold vdma_unf 300 cycles -> unf_count=255; drop ctrl_enable during RECOVER -> buf_flush=0 and IDLE next cycle, counts held.
